disp_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the watch's multi-digit 7-segment display.
- Holds a shadow copy of the BCD time digits and drives one digit at a time into the shared BCD-to-7-segment decoder through bcd_o.
- Drives the matching one-hot digit enable.
- Inserts a guard blanking interval between digits to stop ghosting.
- Accepts new digit values only at frame boundaries, so a frame never mixes old and new time.

---
 rtl/disp_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - time-multiplexed 7-segment digit scan controller (optional blink: SCAN_BLINK_EN)
module disp_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
`ifdef SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
  output logic                    load_ack_o,
  output logic [3:0]              bcd_o,
  output logic [NUM_DIGITS-1:0]   dig_en_o,
  output logic                    blank_o,
  output logic                    frame_o
);

  typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nx;
  logic                    frame_end;
  logic                    capture;
  logic [3:0]              nib_nx;
  logic                    blinked_nx;
  logic                    lit_nx;
  logic                    frame_nx;
  logic [NUM_DIGITS-1:0]   dig_en_nx;

  // Slot/digit counters and the GUARD/SHOW transition for the coming cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CW'(1);
    idx_nx    = idx;
    frame_end = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_nx    = '0;
      frame_end = (idx == IDX_LAST);
      idx_nx    = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
    case (state)
      GUARD:   if (cnt == GUARD_LAST) state_nx = SHOW;
      SHOW:    if (cnt == CNT_LAST) state_nx = GUARD;
      default: state_nx = GUARD;
    endcase
  end

  // New time is only taken on the last cycle of a frame so a frame never mixes digits.
  assign capture    = frame_end & load_i;
  assign load_ack_o = capture;
  assign shadow_nx  = capture ? digits_i : shadow;

  // Nibble for the next cycle comes from the post-capture shadow, so idx 0 of a
  // fresh frame already carries the new value when its guard interval starts.
  assign nib_nx = shadow_nx[{idx_nx, 2'b00} +: 4];

`ifdef SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt, fcnt_nx;
  logic          phase, phase_nx;

  // Frame counter; the blink phase flips each time it wraps.
  always_comb begin
    fcnt_nx  = fcnt;
    phase_nx = phase;
    if (frame_end) begin
      if (fcnt == FCNT_LAST) begin
        fcnt_nx  = '0;
        phase_nx = ~phase;
      end else begin
        fcnt_nx = fcnt + FW'(1);
      end
    end
  end

  // Blink state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else begin
      fcnt  <= fcnt_nx;
      phase <= phase_nx;
    end
  end

  assign blinked_nx = phase_nx & blink_mask_i[idx_nx];
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  assign blinked_nx = 1'b0;
`endif

  // Output decode for the coming cycle: light only valid, unblinked digits in SHOW.
  always_comb begin
    lit_nx    = (state_nx == SHOW) && (nib_nx <= 4'd9) && !blinked_nx;
    dig_en_nx = '0;
    if (lit_nx) dig_en_nx[idx_nx] = 1'b1;
    frame_nx  = (idx_nx == IDX_LAST) && (cnt_nx == CNT_LAST);
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GUARD;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shadow <= shadow_nx;
    end
  end

  // Registered outputs; dig_en_o and bcd_o move on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_en_o <= '0;
      bcd_o    <= '0;
      blank_o  <= 1'b1;
      frame_o  <= 1'b0;
    end else begin
      dig_en_o <= dig_en_nx;
      bcd_o    <= nib_nx;
      blank_o  <= ~lit_nx;
      frame_o  <= frame_nx;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl (blink scenario with SCAN_BLINK_EN)
module tb_disp_scan_ctrl;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int BF  = 2;
  localparam int FR  = N * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  mask = '0;
  logic        load_ack_o;
  logic [3:0]  bcd_o;
  logic [3:0]  dig_en_o;
  logic        blank_o;
  logic        frame_o;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          t = 0;
  logic [15:0] shadow_m = '0;
  logic        exp_ack;
  logic [9:0]  want;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .NUM_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYC(BLK), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digits_i(digits_i),
    .load_i(load_i),
`ifdef SCAN_BLINK_EN
    .blink_mask_i(mask),
`endif
    .load_ack_o(load_ack_o),
    .bcd_o(bcd_o),
    .dig_en_o(dig_en_o),
    .blank_o(blank_o),
    .frame_o(frame_o)
  );

  // Expected {dig_en, bcd, blank, frame} for cycle tc after reset release.
  function automatic logic [9:0] model_out(input int tc, input logic [15:0] s, input logic [3:0] m);
    int idx, pos;
    logic [3:0] nib;
    logic lit, phase;
    idx   = (tc / DIV) % N;
    pos   = tc % DIV;
    nib   = s[idx*4 +: 4];
    phase = (((tc / FR) / BF) % 2) == 1;
    lit   = (pos >= BLK) && (nib <= 4'd9) && !(phase && m[idx]);
    return {lit ? 4'(1 << idx) : 4'b0000, nib, !lit, (tc % FR) == FR - 1};
  endfunction

  task automatic tick();
    if (((t % FR) == FR - 1) && load_i) shadow_m = digits_i;
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({dig_en_o, bcd_o, blank_o, frame_o, load_ack_o} !== 11'b0000_0000_1_0_0) begin
      n_fail++;
      $display("FAIL reset_vals got=%b want=%b", {dig_en_o, bcd_o, blank_o, frame_o, load_ack_o}, 11'b0000_0000_1_0_0);
    end
    @(negedge clk);
    rst = 1'b0;
    load_i = 1'b0;
    t = 0;
    shadow_m = '0;
    for (int i = 0; i < FR; i++) begin
      #1;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL reset_scan t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      tick();
    end
  endtask

  task automatic test_load();
    int acks = 0;
    logic last;
    load_i = 1'b1;
    digits_i = 16'h1234;
    for (int i = 0; i < FR; i++) begin
      #1;
      exp_ack = ((t % FR) == FR - 1) && load_i;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL load_hold t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      n_cmp++;
      if (load_ack_o !== exp_ack) begin
        n_fail++;
        $display("FAIL load_ack t=%0d got=%b want=%b", t, load_ack_o, exp_ack);
      end
      if (load_ack_o === 1'b1) acks++;
      last = (t % FR) == FR - 1;
      tick();
      if (last) break;
    end
    load_i = 1'b0;
    for (int i = 0; i < FR; i++) begin
      #1;
      if ((t % DIV) == 4) begin
        n_cmp++;
        if (bcd_o !== 4'(4 - (t / DIV) % N) || dig_en_o !== 4'(1 << ((t / DIV) % N))) begin
          n_fail++;
          $display("FAIL load_show t=%0d bcd=%h en=%b want_bcd=%h", t, bcd_o, dig_en_o, 4'(4 - (t / DIV) % N));
        end
      end
      tick();
    end
    n_cmp++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL load_ack_count got=%0d want=1", acks);
    end
  endtask

  task automatic test_no_load();
    int acks = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      if ((t % FR) == 12) digits_i = 16'h5678;
      load_i = ((t % FR) != FR - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL noload t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      if ((t % DIV) == 4) begin
        n_cmp++;
        if (bcd_o !== 4'(4 - (t / DIV) % N)) begin
          n_fail++;
          $display("FAIL noload_bcd t=%0d got=%h want=%h", t, bcd_o, 4'(4 - (t / DIV) % N));
        end
      end
      if (load_ack_o !== 1'b0) acks++;
      tick();
    end
    load_i = 1'b0;
    n_cmp++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL noload_ack_count got=%0d want=0", acks);
    end
  endtask

  task automatic test_invalid();
    logic last;
    load_i = 1'b1;
    digits_i = 16'h9A09;
    for (int i = 0; i < FR; i++) begin
      #1;
      last = (t % FR) == FR - 1;
      tick();
      if (last) break;
    end
    load_i = 1'b0;
    for (int i = 0; i < FR; i++) begin
      #1;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL invalid t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      if ((t % FR) == 2 * DIV + 4) begin
        n_cmp++;
        if ({dig_en_o, blank_o, bcd_o} !== {4'b0000, 1'b1, 4'hA}) begin
          n_fail++;
          $display("FAIL invalid_d2 got=%b want=%b", {dig_en_o, blank_o, bcd_o}, {4'b0000, 1'b1, 4'hA});
        end
      end
      if ((t % FR) == 3 * DIV + 4) begin
        n_cmp++;
        if ({dig_en_o, blank_o, bcd_o} !== {4'b1000, 1'b0, 4'h9}) begin
          n_fail++;
          $display("FAIL invalid_d3 got=%b want=%b", {dig_en_o, blank_o, bcd_o}, {4'b1000, 1'b0, 4'h9});
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6 * FR; i++) begin
      digits_i = 16'($urandom);
      load_i = 1'($urandom_range(0, 1));
      #1;
      exp_ack = ((t % FR) == FR - 1) && load_i;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL random t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      n_cmp++;
      if (load_ack_o !== exp_ack) begin
        n_fail++;
        $display("FAIL random_ack t=%0d got=%b want=%b", t, load_ack_o, exp_ack);
      end
      tick();
    end
    load_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_i = 1'b0;
    for (int i = 0; i < FR && (t % FR) != 2 * DIV + 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({dig_en_o, bcd_o, blank_o, frame_o, load_ack_o} !== 11'b0000_0000_1_0_0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b want=%b", {dig_en_o, bcd_o, blank_o, frame_o, load_ack_o}, 11'b0000_0000_1_0_0);
    end
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    shadow_m = '0;
    for (int i = 0; i < FR; i++) begin
      #1;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL reset_mid_scan t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      tick();
    end
  endtask

`ifdef SCAN_BLINK_EN
  task automatic test_blink();
    mask = 4'b0010;
    load_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    shadow_m = '0;
    for (int i = 0; i < 4 * FR; i++) begin
      #1;
      want = model_out(t, shadow_m, mask);
      n_cmp++;
      if ({dig_en_o, bcd_o, blank_o, frame_o} !== want) begin
        n_fail++;
        $display("FAIL blink t=%0d got=%h want=%h", t, {dig_en_o, bcd_o, blank_o, frame_o}, want);
      end
      if ((t % FR) == DIV + 4) begin
        n_cmp++;
        if (dig_en_o !== (((t / FR) % 4) < 2 ? 4'b0010 : 4'b0000)) begin
          n_fail++;
          $display("FAIL blink_d1 frame=%0d got=%b", t / FR, dig_en_o);
        end
      end
      tick();
    end
    mask = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_no_load();
    test_invalid();
    test_random();
    test_reset_mid();
`ifdef SCAN_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
